// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter FSM encoding and a clog2 helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } uart_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for the asynchronous rxd pad plus a falling-edge detector.
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic [2:0] sync_q;

    // Reset to the idle (high) line level so reset itself never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rxd};
        end
    end

    assign rxd_s = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits, error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] word,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 busy
);

    localparam int unsigned CntW = clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = clog2(DATA_BITS + 1);

    localparam logic [CntW-1:0] CntLast     = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf     = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxDataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] IdxStopLast = IdxW'(STOP_BITS - 1);
    localparam logic            ParEn       = 1'(PARITY != PAR_NONE);
    localparam logic            ParTarget   = 1'(PARITY == PAR_ODD);

    logic rxd_s;
    logic fall;

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 stop0_q, stop0_d;

    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 brk_q, brk_d;

    logic fe_now;
    logic stop0_now;

    uart_sync_edge u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    // Values including the stop sample taken this cycle, so completion sees the whole frame.
    assign fe_now    = ferr_acc_q | ~rxd_s;
    assign stop0_now = (idx_q == '0) ? rxd_s : stop0_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        ferr_acc_d   = ferr_acc_q;
        stop0_d      = stop0_q;
        word_d       = word_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        brk_d        = brk_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    if (rxd_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StData;
                        cnt_d      = '0;
                        idx_d      = '0;
                        ferr_acc_d = 1'b0;
                        par_d      = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IdxDataLast) begin
                        idx_d   = '0;
                        state_d = ParEn ? StPar : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPar: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    par_d   = rxd_s;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d      = '0;
                    idx_d      = idx_q + 1'b1;
                    ferr_acc_d = fe_now;
                    stop0_d    = stop0_now;
                    if (idx_q == IdxStopLast) begin
                        state_d      = StIdle;
                        idx_d        = '0;
                        valid_d      = 1'b1;
                        word_d       = shreg_q;
                        parity_err_d = ParEn & ((^{shreg_q, par_q}) != ParTarget);
                        frame_err_d  = fe_now;
                        brk_d        = ~(|shreg_q) & (~ParEn | ~par_q) & ~stop0_now;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            ferr_acc_q   <= 1'b0;
            stop0_q      <= 1'b1;
            word_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            ferr_acc_q   <= ferr_acc_d;
            stop0_q      <= stop0_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
        end
    end

    assign word       = word_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign brk        = brk_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: default receiver (8N1) and a 7-bit even-parity 2-stop receiver side by side.
module tb_uart_rx_param;

    localparam int CPB     = 16;
    localparam int FRAME_B = (1 + 7 + 1 + 2) * CPB;

    typedef struct {
        logic [8:0] word;
        logic       pe;
        logic       fe;
        logic       brk;
        bit         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic [7:0] word_a;
    logic [6:0] word_b;
    logic       valid_a, pe_a, fe_a, brk_a, busy_a;
    logic       valid_b, pe_b, fe_b, brk_b, busy_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_b = 0;

    uart_rx_param dut_a (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd_a),
        .word       (word_a),
        .valid      (valid_a),
        .parity_err (pe_a),
        .frame_err  (fe_a),
        .brk        (brk_a),
        .busy       (busy_a)
    );

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (7),
        .PARITY       (2),
        .STOP_BITS    (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd_b),
        .word       (word_b),
        .valid      (valid_b),
        .parity_err (pe_b),
        .frame_err  (fe_b),
        .brk        (brk_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitors: every valid strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_a: got word %0h, expected no frame", word_a);
            end else begin
                ea = qa.pop_front();
                check("word_a", 32'(word_a), 32'(ea.word));
                check("parity_err_a", 32'(pe_a), 32'(ea.pe));
                check("frame_err_a", 32'(fe_a), 32'(ea.fe));
                check("brk_a", 32'(brk_a), 32'(ea.brk));
                check("busy_a_done", 32'(busy_a), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_b: got word %0h, expected no frame", word_b);
            end else begin
                eb = qb.pop_front();
                check("word_b", 32'(word_b), 32'(eb.word));
                check("parity_err_b", 32'(pe_b), 32'(eb.pe));
                check("frame_err_b", 32'(fe_b), 32'(eb.fe));
                check("brk_b", 32'(brk_b), 32'(eb.brk));
                if (eb.gap) check("gap_b", 32'(cyc - last_b), 32'(FRAME_B));
            end
            last_b = cyc;
        end
    end

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 1) rxd_b = v;
        else rxd_a = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int sel, input int n);
        if (sel == 1) rxd_b = 1'b1;
        else rxd_a = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: expected outcome from the frame's bit-level contents.
    task automatic send_frame(input int sel, input logic [8:0] data, input logic par,
                              input logic s0, input logic s1, input bit gap);
        int         nb;
        bit         has_par;
        logic [8:0] d;
        exp_t       e;
        nb      = (sel == 1) ? 7 : 8;
        has_par = (sel == 1);
        d       = data & ((9'd1 << nb) - 9'd1);
        e.word  = d;
        e.pe    = has_par && (((^d) ^ par) != 1'b0);
        e.fe    = !s0 || (has_par && !s1);
        e.brk   = (d == 9'd0) && (!has_par || !par) && !s0;
        e.gap   = gap;
        if (sel == 1) qb.push_back(e);
        else qa.push_back(e);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, s0);
        if (sel == 1) drive_bit(sel, s1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (qa.size() != 0 || qb.size() != 0); i++) begin
            @(negedge clk);
        end
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);
    endtask

    task automatic seq_a();
        exp_t e;
        int   gap;
        logic s0;
        logic [8:0] d;
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(0, 20);
        // False start: 4-cycle low pulse must be rejected at the start sample.
        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        rxd_a = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", 32'(busy_a), 32'd1);
        repeat (20) @(negedge clk);
        check("glitch_busy_low", 32'(busy_a), 32'd0);
        check("glitch_word_kept", 32'(word_a), 32'h0A5);
        // Break: line held low for 12 bit times yields exactly one frame.
        e.word = 9'd0;
        e.pe   = 1'b0;
        e.fe   = 1'b1;
        e.brk  = 1'b1;
        e.gap  = 1'b0;
        qa.push_back(e);
        rxd_a = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        idle(0, 2 * CPB);
        for (int n = 0; n < 12; n++) begin
            d   = 9'($urandom_range(0, 255));
            s0  = ($urandom_range(0, 5) != 0);
            gap = s0 ? ($urandom_range(0, 1) * $urandom_range(0, 40))
                     : (CPB + $urandom_range(0, 10));
            send_frame(0, d, 1'b0, s0, 1'b1, 1'b0);
            if (gap > 0) idle(0, gap);
        end
        idle(0, CPB);
        send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(0, 2 * CPB);
    endtask

    task automatic seq_b();
        logic [8:0] d;
        logic       par, s0, s1;
        int         gap;
        bit         prev_zero;
        send_frame(1, 9'h03C, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1, 30);
        send_frame(1, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 30);
        send_frame(1, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1, 9'h02A, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1, 2 * CPB);
        prev_zero = 1'b0;
        for (int n = 0; n < 12; n++) begin
            d   = 9'($urandom_range(0, 127));
            par = (^d) ^ ($urandom_range(0, 4) == 0);
            s0  = ($urandom_range(0, 5) != 0);
            s1  = ($urandom_range(0, 5) != 0);
            gap = s1 ? ($urandom_range(0, 1) * $urandom_range(0, 30))
                     : (CPB + $urandom_range(0, 10));
            send_frame(1, d, par, s0, s1, prev_zero);
            prev_zero = (gap == 0);
            if (gap > 0) idle(1, gap);
        end
        idle(1, 2 * CPB);
    endtask

    initial begin
        #12;
        check("rst_word_a", 32'(word_a), 32'd0);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_flags_a", 32'({pe_a, fe_a, brk_a}), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        fork
            seq_a();
            seq_b();
        join
        drain();

        // Abort mid-frame: 0xF0 is high from data bit 4 on, so the tail has no falling edge.
        rxd_a = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rxd_a = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("pre_abort_busy_a", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_word_a", 32'(word_a), 32'd0);
        check("abort_flags_a", 32'({valid_a, pe_a, fe_a, brk_a}), 32'd0);
        check("abort_busy_a", 32'(busy_a), 32'd0);
        check("abort_word_b", 32'(word_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        check("post_abort_busy_a", 32'(busy_a), 32'd0);
        send_frame(0, 9'h081, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(0, 2 * CPB);
        drain();
        check("final_word_a", 32'(word_a), 32'h081);
        check("final_busy", 32'({busy_a, busy_b}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
